// File: rtl/stereo_stream_pkg.sv
// Shared types and constants for the stereo gray stream blocks.
// Holds the scheduler state encoding, the source numbering and the
// canonical gray beat layout used on the converter-side stream.
package stereo_stream_pkg;

   typedef enum logic {
      WAIT_SOF = 1'b0,
      PASS     = 1'b1
   } sched_state_t;

   localparam int unsigned SRC_LEFT  = 0;
   localparam int unsigned SRC_RIGHT = 1;
   localparam int unsigned SRC_DISP  = 2;

   localparam int unsigned GRAY_DATA_WIDTH = 8;
   localparam int unsigned GRAY_PPC        = 4;
   localparam int unsigned GRAY_BEAT_W     = GRAY_DATA_WIDTH * GRAY_PPC;

   typedef struct packed {
      logic [GRAY_BEAT_W-1:0] data;
      logic                   user;
      logic                   last;
   } gray_beat_t;

endpackage

// File: rtl/axis_reg_slice.sv
// One-stage AXI4-Stream register slice.
// The payload is loaded whenever the stage is empty or being drained, so a
// held beat stays stable while the downstream stalls. Full throughput.
module axis_reg_slice #(
   parameter int WIDTH = 34
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   input  logic             i_ready
);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;

   assign o_ready = !r_valid || i_ready;
   assign o_valid = r_valid;
   assign o_data  = r_data;

   // Load a new beat (or go empty) whenever the current one can leave.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (o_ready) begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_data <= i_data;
         end
      end
   end

endmodule

// File: rtl/gray_stream_sched.sv
// Frame-synchronous scheduler sharing one gray-to-YUV422 converter between
// N_SRC gray AXI4-Stream sources. Source switches take effect only at a
// start of frame, so the converter never sees a torn frame.
// Optional build macro GRAY_SCHED_DRAIN_EN: when defined, unselected sources
// are drained (tready=1, beats dropped); otherwise they are backpressured.
module gray_stream_sched #(
   parameter  int DATA_WIDTH  = 8,
   parameter  int PPC         = 4,
   parameter  int N_SRC       = 3,
   parameter  int FRAME_LINES = 1080,
   localparam int SEL_W       = $clog2(N_SRC)
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic [SEL_W-1:0]              sel,
   input  logic [N_SRC-1:0]              s_axis_tvalid,
   input  logic [N_SRC*DATA_WIDTH*PPC-1:0] s_axis_tdata,
   input  logic [N_SRC-1:0]              s_axis_tuser,
   input  logic [N_SRC-1:0]              s_axis_tlast,
   output logic [N_SRC-1:0]              s_axis_tready,
   output logic                          m_axis_gray_tvalid,
   output logic [DATA_WIDTH*PPC-1:0]     m_axis_gray_tdata,
   output logic                          m_axis_gray_tuser,
   output logic                          m_axis_gray_tlast,
   input  logic                          m_axis_gray_tready,
   output logic [SEL_W-1:0]              active_src,
   output logic                          frame_done,
   output logic                          sof_err
);

   import stereo_stream_pkg::*;

   localparam int BEAT_W = DATA_WIDTH * PPC;
   localparam int LINE_W = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
   localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(FRAME_LINES - 1);
   localparam logic [SEL_W-1:0]  SEL_MAX   = SEL_W'(N_SRC - 1);

   sched_state_t      r_state;
   sched_state_t      w_stateNext;
   logic [SEL_W-1:0]  r_cand;
   logic [SEL_W-1:0]  r_active;
   logic [SEL_W-1:0]  w_src;
   logic [LINE_W-1:0] r_lineCnt;
   logic [LINE_W-1:0] w_lineNext;
   logic [LINE_W-1:0] w_lineBase;
   logic              r_run;
   logic              r_frameDone;
   logic              r_sofErr;

   logic              w_srcValid;
   logic              w_srcUser;
   logic              w_srcLast;
   logic [BEAT_W-1:0] w_srcData;
   logic              w_srcReady;
   logic              w_fwd;
   logic              w_frameEnd;
   logic              w_sofErr;
   logic              w_sliceReady;
   logic [BEAT_W+1:0] w_sliceIn;
   logic [BEAT_W+1:0] w_sliceOut;
   logic [BEAT_W-1:0] w_dataArr [N_SRC];

   for (genvar k = 0; k < N_SRC; k++) begin : g_unpack
      assign w_dataArr[k] = s_axis_tdata[k*BEAT_W +: BEAT_W];
   end

   // While waiting for SOF the candidate is watched; during a frame only the
   // locked source is.
   assign w_src      = (r_state == PASS) ? r_active : r_cand;
   assign w_srcValid = s_axis_tvalid[w_src];
   assign w_srcUser  = s_axis_tuser[w_src];
   assign w_srcLast  = s_axis_tlast[w_src];
   assign w_srcData  = w_dataArr[w_src];

   // A SOF beat restarts line counting, whether it opens a frame or
   // arrives unexpectedly mid-frame.
   assign w_lineBase = w_srcUser ? '0 : r_lineCnt;

   // Decide acceptance/forwarding of the watched source and the next state.
   always_comb begin
      w_stateNext = r_state;
      w_lineNext  = r_lineCnt;
      w_srcReady  = 1'b0;
      w_fwd       = 1'b0;
      w_frameEnd  = 1'b0;
      w_sofErr    = 1'b0;
      case (r_state)
         WAIT_SOF: begin
            w_srcReady = w_srcUser ? w_sliceReady : 1'b1;
            w_fwd      = w_srcValid && w_srcUser && w_sliceReady;
         end
         PASS: begin
            w_srcReady = w_sliceReady;
            w_fwd      = w_srcValid && w_sliceReady;
            w_sofErr   = w_fwd && w_srcUser;
         end
         default: begin
            w_srcReady = 1'b0;
         end
      endcase
      if (!r_run) begin
         w_srcReady = 1'b0;
         w_fwd      = 1'b0;
         w_sofErr   = 1'b0;
      end
      if (w_fwd) begin
         w_stateNext = PASS;
         w_lineNext  = w_lineBase;
         if (w_srcLast) begin
            if (w_lineBase == LAST_LINE) begin
               w_lineNext  = '0;
               w_frameEnd  = 1'b1;
               w_stateNext = WAIT_SOF;
            end else begin
               w_lineNext = w_lineBase + 1'b1;
            end
         end
      end
   end

   // Ready fan-out: the watched source follows the decision above, the rest
   // are drained or stalled depending on the build.
   always_comb begin
      s_axis_tready = '0;
`ifdef GRAY_SCHED_DRAIN_EN
      if (r_run) begin
         s_axis_tready = '1;
      end
`endif
      s_axis_tready[w_src] = w_srcReady;
   end

   // Scheduler state, line counter, source latches and registered pulses.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state     <= WAIT_SOF;
         r_cand      <= '0;
         r_active    <= '0;
         r_lineCnt   <= '0;
         r_run       <= 1'b0;
         r_frameDone <= 1'b0;
         r_sofErr    <= 1'b0;
      end else begin
         r_run       <= 1'b1;
         r_state     <= w_stateNext;
         r_lineCnt   <= w_lineNext;
         r_frameDone <= w_frameEnd;
         r_sofErr    <= w_sofErr;
         if (r_state == WAIT_SOF && w_fwd) begin
            r_active <= r_cand;
         end
         if ((r_state == WAIT_SOF || w_frameEnd) && sel <= SEL_MAX) begin
            r_cand <= sel;
         end
      end
   end

   assign w_sliceIn = {w_srcUser, w_srcLast, w_srcData};

   axis_reg_slice #(
      .WIDTH (BEAT_W + 2)
   ) u_outSlice (
      .aclk    (aclk),
      .aresetn (aresetn),
      .i_valid (w_fwd),
      .i_data  (w_sliceIn),
      .o_ready (w_sliceReady),
      .o_valid (m_axis_gray_tvalid),
      .o_data  (w_sliceOut),
      .i_ready (m_axis_gray_tready)
   );

   assign m_axis_gray_tuser = w_sliceOut[BEAT_W+1];
   assign m_axis_gray_tlast = w_sliceOut[BEAT_W];
   assign m_axis_gray_tdata = w_sliceOut[BEAT_W-1:0];
   assign active_src        = r_active;
   assign frame_done        = r_frameDone;
   assign sof_err           = r_sofErr;

endmodule

// File: tb/tb_gray_stream_sched.sv
// Directed testbench for gray_stream_sched (N_SRC=3, FRAME_LINES=4).
// Each line is two beats; the second carries tlast.
module tb_gray_stream_sched;

   import stereo_stream_pkg::*;

   localparam int DW = 8;
   localparam int PP = 4;
   localparam int NS = 3;
   localparam int FL = 4;
   localparam int BW = DW * PP;
   localparam int SW = 2;
`ifdef GRAY_SCHED_DRAIN_EN
   localparam logic [63:0] DRAIN_EXP = 64'd1;
`else
   localparam logic [63:0] DRAIN_EXP = 64'd0;
`endif

   logic             aclk = 1'b0;
   logic             aresetn = 1'b0;
   logic [SW-1:0]    sel = '0;
   logic [NS-1:0]    s_tvalid = '0;
   logic [NS*BW-1:0] s_tdata = '0;
   logic [NS-1:0]    s_tuser = '0;
   logic [NS-1:0]    s_tlast = '0;
   logic [NS-1:0]    s_tready;
   logic             m_tvalid;
   logic [BW-1:0]    m_tdata;
   logic             m_tuser;
   logic             m_tlast;
   logic             m_tready = 1'b1;
   logic [SW-1:0]    active_src;
   logic             frame_done;
   logic             sof_err;

   gray_beat_t capQ[$];
   gray_beat_t expQ[$];
   int totalCount = 0;
   int badCount = 0;
   int fdCnt = 0;
   int seCnt = 0;
   logic stallPrev = 1'b0;
   logic [BW+2:0] holdPrev = '0;
   logic bpOn = 1'b0;
   int bpIdx = 0;
   logic [3:0] bpPat = 4'b1001;

   always #5 aclk = ~aclk;

   gray_stream_sched #(
      .DATA_WIDTH  (DW),
      .PPC         (PP),
      .N_SRC       (NS),
      .FRAME_LINES (FL)
   ) dut (
      .aclk               (aclk),
      .aresetn            (aresetn),
      .sel                (sel),
      .s_axis_tvalid      (s_tvalid),
      .s_axis_tdata       (s_tdata),
      .s_axis_tuser       (s_tuser),
      .s_axis_tlast       (s_tlast),
      .s_axis_tready      (s_tready),
      .m_axis_gray_tvalid (m_tvalid),
      .m_axis_gray_tdata  (m_tdata),
      .m_axis_gray_tuser  (m_tuser),
      .m_axis_gray_tlast  (m_tlast),
      .m_axis_gray_tready (m_tready),
      .active_src         (active_src),
      .frame_done         (frame_done),
      .sof_err            (sof_err)
   );

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      totalCount++;
      if (obs !== exp) begin
         badCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Output monitor: captures transfers, counts pulses and checks that a
   // stalled beat is held unchanged into the next cycle.
   always @(negedge aclk) begin
      if (stallPrev) begin
         checkOutput("stall_hold", 64'({m_tvalid, m_tuser, m_tlast, m_tdata}), 64'(holdPrev));
      end
      stallPrev <= m_tvalid && !m_tready && aresetn;
      holdPrev  <= {m_tvalid, m_tuser, m_tlast, m_tdata};
      if (aresetn && m_tvalid && m_tready) begin
         capQ.push_back(gray_beat_t'({m_tdata, m_tuser, m_tlast}));
      end
      if (frame_done) fdCnt <= fdCnt + 1;
      if (sof_err) seCnt <= seCnt + 1;
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge aclk);
         #1;
      end
   endtask

   task automatic applyStimulus(input int src, input logic [BW-1:0] d, input logic u,
                                input logic l, input bit fwd);
      int  n = 0;
      bit  done = 0;
      s_tvalid[src] = 1'b1;
      s_tdata[src*BW +: BW] = d;
      s_tuser[src] = u;
      s_tlast[src] = l;
      while (!done) begin
         @(negedge aclk);
         if (s_tready[src]) done = 1;
         @(posedge aclk);
         #1;
         n++;
         if (!done && n >= 200) begin
            totalCount++;
            badCount++;
            $display("[TB] FAIL accept_timeout: src %0d got no ready, required ready within 200 cycles", src);
            done = 1;
         end
      end
      s_tvalid[src] = 1'b0;
      s_tuser[src] = 1'b0;
      s_tlast[src] = 1'b0;
      if (fwd) expQ.push_back(gray_beat_t'({d, u, l}));
   endtask

   task automatic sendLine(input int src, input logic [7:0] tag, input logic [7:0] line,
                           input logic sof, input bit fwd);
      applyStimulus(src, {8'(src), tag, line, 8'd0}, sof, 1'b0, fwd);
      applyStimulus(src, {8'(src), tag, line, 8'd1}, 1'b0, 1'b1, fwd);
   endtask

   task automatic checkCapture(input string tag);
      int n;
      checkOutput({tag, "_count"}, 64'(capQ.size()), 64'(expQ.size()));
      n = (capQ.size() < expQ.size()) ? capQ.size() : expQ.size();
      for (int i = 0; i < n; i++) begin
         checkOutput($sformatf("%s_beat%0d", tag, i), 64'(capQ[i]), 64'(expQ[i]));
      end
      capQ.delete();
      expQ.delete();
   endtask

   initial begin
      // Reset values
      sel = 2'd1;
      repeat (3) @(negedge aclk);
      checkOutput("rst_tvalid", 64'(m_tvalid), 64'd0);
      checkOutput("rst_tdata", 64'(m_tdata), 64'd0);
      checkOutput("rst_user_last", 64'({m_tuser, m_tlast}), 64'd0);
      checkOutput("rst_tready", 64'(s_tready), 64'd0);
      checkOutput("rst_active", 64'(active_src), 64'd0);
      checkOutput("rst_pulses", 64'({frame_done, sof_err}), 64'd0);
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      idle(3);

      // Startup: pre-SOF beats of source 1 are dropped, then a full frame
      @(negedge aclk);
      checkOutput("t1_cand_ready", 64'(s_tready[1]), 64'd1);
      checkOutput("t1_unsel_ready", 64'(s_tready[0]), DRAIN_EXP);
      @(posedge aclk);
      #1;
      for (int i = 0; i < 3; i++) applyStimulus(1, {8'd1, 8'hEE, 8'd0, 8'(i)}, 1'b0, 1'b0, 0);
      for (int ln = 0; ln < FL; ln++) sendLine(1, 8'h10, 8'(ln), ln == 0, 1);
      idle(3);
      if (capQ.size() > 0) checkOutput("t1_first_user", 64'(capQ[0].user), 64'd1);
      checkCapture("t1");
      checkOutput("t1_frame_done", 64'(fdCnt), 64'd1);
      checkOutput("t1_active", 64'(active_src), 64'd1);

      // Mid-frame switch: source 0 finishes, source 2 joins at its SOF
      sel = 2'd0;
      idle(2);
      sendLine(0, 8'h20, 8'd0, 1'b1, 1);
      sendLine(0, 8'h20, 8'd1, 1'b0, 1);
      sel = 2'd2;
      idle(2);
      checkOutput("t2_active_mid", 64'(active_src), 64'd0);
      @(negedge aclk);
      checkOutput("t2_unsel1_ready", 64'(s_tready[1]), DRAIN_EXP);
      checkOutput("t2_unsel2_ready", 64'(s_tready[2]), DRAIN_EXP);
      @(posedge aclk);
      #1;
      sendLine(0, 8'h20, 8'd2, 1'b0, 1);
      sendLine(0, 8'h20, 8'd3, 1'b0, 1);
      idle(2);
      checkOutput("t2_active_end", 64'(active_src), 64'd0);
      checkOutput("t2_frame_done0", 64'(fdCnt), 64'd2);
      applyStimulus(2, {8'd2, 8'hEE, 8'd9, 8'd9}, 1'b0, 1'b0, 0);
      idle(2);
      checkOutput("t2_active_presof", 64'(active_src), 64'd0);
      for (int ln = 0; ln < FL; ln++) sendLine(2, 8'h21, 8'(ln), ln == 0, 1);
      idle(3);
      checkOutput("t2_active_new", 64'(active_src), 64'd2);
      checkOutput("t2_frame_done2", 64'(fdCnt), 64'd3);
      checkCapture("t2");

      // Backpressure: converter ready cycles 1,0,0,1
      bpIdx = 0;
      bpOn = 1'b1;
      fork
         begin
            while (bpOn) begin
               m_tready = bpPat[bpIdx % 4];
               bpIdx++;
               @(posedge aclk);
               #1;
            end
            m_tready = 1'b1;
         end
         begin
            for (int ln = 0; ln < FL; ln++) sendLine(2, 8'h30, 8'(ln), ln == 0, 1);
            bpOn = 1'b0;
         end
      join
      idle(4);
      checkCapture("t3");
      checkOutput("t3_frame_done", 64'(fdCnt), 64'd4);

      // Mid-frame SOF on line 2 restarts the frame count
      sendLine(2, 8'h40, 8'd0, 1'b1, 1);
      sendLine(2, 8'h40, 8'd1, 1'b0, 1);
      sendLine(2, 8'h40, 8'd2, 1'b1, 1);
      sendLine(2, 8'h40, 8'd3, 1'b0, 1);
      sendLine(2, 8'h40, 8'd4, 1'b0, 1);
      idle(2);
      checkOutput("t4_sof_err", 64'(seCnt), 64'd1);
      checkOutput("t4_no_done_yet", 64'(fdCnt), 64'd4);
      sendLine(2, 8'h40, 8'd5, 1'b0, 1);
      idle(3);
      checkOutput("t4_frame_done", 64'(fdCnt), 64'd5);
      checkOutput("t4_sof_err_once", 64'(seCnt), 64'd1);
      checkCapture("t4");

      // Reset during line 2: partial frame is abandoned
      sendLine(2, 8'h50, 8'd0, 1'b1, 1);
      sendLine(2, 8'h50, 8'd1, 1'b0, 1);
      applyStimulus(2, {8'd2, 8'h50, 8'd2, 8'd0}, 1'b0, 1'b0, 1);
      idle(2);
      aresetn = 1'b0;
      @(negedge aclk);
      checkOutput("t5_rst_tvalid", 64'(m_tvalid), 64'd0);
      checkOutput("t5_rst_tready", 64'(s_tready), 64'd0);
      checkOutput("t5_rst_active", 64'(active_src), 64'd0);
      @(negedge aclk);
      checkOutput("t5_rst_tdata", 64'({m_tuser, m_tlast, m_tdata}), 64'd0);
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      idle(3);
      applyStimulus(2, {8'd2, 8'h50, 8'd2, 8'd1}, 1'b0, 1'b1, 0);
      sendLine(2, 8'h50, 8'd3, 1'b0, 0);
      idle(3);
      checkOutput("t5_no_done", 64'(fdCnt), 64'd5);
      checkCapture("t5a");
      for (int ln = 0; ln < FL; ln++) sendLine(2, 8'h51, 8'(ln), ln == 0, 1);
      idle(3);
      checkOutput("t5_frame_done", 64'(fdCnt), 64'd6);
      checkOutput("t5_active", 64'(active_src), 64'd2);
      checkCapture("t5b");

      $display("test done: total=%0d bad=%0d", totalCount, badCount);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation still running, required to finish earlier");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/gray_stream_sched.md
# gray_stream_sched

Frame-synchronous scheduler that shares the single gray-to-YUV422 output converter between `N_SRC` gray AXI4-Stream sources: left camera, right camera and disparity map. The source is selected through the `sel` register input, but a switch takes effect only at a frame boundary, so the converter never sees a torn frame. The block sits directly upstream of the converter. It has a one-stage registered output and reports the active source, frame completion and start-of-frame protocol errors.

## Interface
- `DATA_WIDTH`, 8, bits per pixel
- `PPC`, 4, pixels per beat
- `N_SRC`, 3, number of gray sources (2..8)
- `FRAME_LINES`, 1080, `tlast`-terminated lines per frame
- `aclk`  in  1  clock; all logic is on the rising edge
- `aresetn`  in  1  reset, asynchronous assert, active-low
- `sel`  in  `SEL_W=$clog2(N_SRC)`  requested source, quasi-static
- `s_axis_tvalid`  in  `N_SRC`  per-source valid
- `s_axis_tdata`  in  `N_SRC*DATA_WIDTH*PPC`  source k in slice `[k*DATA_WIDTH*PPC +: DATA_WIDTH*PPC]`
- `s_axis_tuser`  in  `N_SRC`  per-source start of frame (SOF)
- `s_axis_tlast`  in  `N_SRC`  per-source end of line
- `s_axis_tready`  out  `N_SRC`  per-source ready
- `m_axis_gray_tvalid`, `_tdata` (`DATA_WIDTH*PPC`), `_tuser`, `_tlast`  out  converter-side stream
- `m_axis_gray_tready`  in  1  converter ready
- `active_src`  out  `SEL_W`  source currently forwarded
- `frame_done`  out  1  one-cycle pulse when the last line of a frame is accepted
- `sof_err`  out  1  one-cycle pulse when an unexpected SOF arrives mid-frame

## Operation
- FSM states:
  - WAIT_SOF: latch `cand = sel` every cycle. If `sel >= N_SRC`, keep the previous `cand`.
  - WAIT_SOF exit: on a beat from `cand` with `tvalid & tuser`, set `active_src = cand`, clear `line_cnt`, forward that beat and go to PASS.
  - WAIT_SOF discard: beats from `cand` without `tuser` are discarded. `tready[cand]` is 1 and nothing is forwarded.
  - PASS: forward `active_src` only. `sel` changes are ignored.
  - PASS line counting: each accepted beat with `tlast` increments `line_cnt`.
  - PASS frame end: when `line_cnt == FRAME_LINES-1` and a `tlast` beat is accepted, pulse `frame_done` and go to WAIT_SOF.
- Mid-frame SOF: a beat from the active source with `tuser` while in PASS is forwarded. `line_cnt` clears to 0 and `sof_err` pulses; the new frame is counted from that beat.
- Unselected sources: behaviour is governed by `GRAY_SCHED_DRAIN_EN` (see Configuration).
- Data, `tuser` and `tlast` pass through unmodified; there is no arithmetic on pixels.
- `line_cnt` width is `$clog2(FRAME_LINES)`. It never wraps, because it is cleared at frame end.

## Timing
- Output register:
  - Latency: 1 cycle from source acceptance to `m_axis_gray_tvalid`.
  - Throughput: 1 beat/clk.
  - Ready of the forwarded source: `s_axis_tready[active] = !m_valid | m_axis_gray_tready`.
- Output handshake rule: while `m_axis_gray_tvalid & !m_axis_gray_tready`, the outputs hold stable.
- Reset values: all `m_axis_gray_*` outputs 0, `s_axis_tready` all 0, `active_src` 0, `frame_done` 0, `sof_err` 0. The state is WAIT_SOF with `cand` 0.
- Reset mid-frame: the output register is dropped immediately. After release the block waits for a fresh SOF, so the partial frame is never completed.
- Frame back-to-back: frame end and the next SOF can be accepted on consecutive cycles. The WAIT_SOF decision uses the `cand` latched on the first WAIT_SOF cycle, so the gap is zero cycles.
- Pulse timing: `frame_done` and `sof_err` are registered and assert the cycle after the triggering acceptance.

## Configuration
- `GRAY_SCHED_DRAIN_EN` defined: unselected sources see `tready = 1` and their beats are discarded. Cameras never stall, and a switched-to source is joined at its next SOF.
- `GRAY_SCHED_DRAIN_EN` undefined: unselected sources see `tready = 0` and are backpressured. They must tolerate stalling.

## Structure
- Package `stereo_stream_pkg` holds:
  - the `sched_state_t` enum {`WAIT_SOF`, `PASS`};
  - the `SRC_LEFT=0`, `SRC_RIGHT=1`, `SRC_DISP=2` constants;
  - a `gray_beat_t` struct {`data`, `user`, `last`} parameterized via localparam widths.
- One sub-module, `axis_reg_slice`, implements the output register stage (valid/data/user/last with a ready-gated load). It is reusable by the other stream blocks.

## Test plan
- Startup: `N_SRC=3`, `FRAME_LINES=4`, `sel=1`, source 1 sends 3 beats, then an SOF beat, then 4 lines -> the first 3 beats are dropped. Output shows exactly 4 lines starting with `tuser=1`, and `frame_done` pulses once.
- Mid-frame switch: `sel` goes 0→2 after line 1 of a source-0 frame -> source 0 finishes all 4 lines. `active_src` becomes 2 only at source 2's next SOF.
- Backpressure: `m_axis_gray_tready` toggles 1,0,0,1 during a frame -> no beat is lost or duplicated. The output is stable while stalled, and the data sequence matches the input.
- Mid-frame SOF: `tuser=1` on line 2 of the active source -> `sof_err` pulses once. Four further lines are then needed before `frame_done`.
- Reset mid-frame: `aresetn` is low for 2 cycles during line 2 -> all outputs are 0 during reset. After release, no output appears until the next SOF.
- Drain macro: with `GRAY_SCHED_DRAIN_EN`, unselected source 1 gets `s_axis_tready[1]=1` continuously. Without the macro it gets `s_axis_tready[1]=0`.
